// File: rtl/fetch_prefetch_queue_pkg.sv
// Shared types for the instruction prefetch queue: FSM states and the
// {instruction, PC+4} entry carried through the FIFO.
package fetch_prefetch_queue_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [INSTR_W-1:0] pc4;
  } entry_t;

endpackage

// File: rtl/fetch_prefetch_queue_fifo.sv
// First-word fall-through FIFO of prefetch entries with synchronous flush.
// Kept generic so the data-side buffer can reuse it.
module prefetch_fifo
  import fetch_prefetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  entry_t                   data_i,
  input  logic                     pop_i,
  output entry_t                   data_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wptr_q;
  logic [AW-1:0]   rptr_q;
  logic [CW-1:0]   count_q;
  logic            full;
  logic            push_ok;
  logic            pop_ok;

  assign full    = (count_q == FULL_CNT);
  assign push_ok = push_i && !full;
  assign pop_ok  = pop_i && (count_q != '0);
  assign data_o  = mem_q[rptr_q];
  assign count_o = count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wptr_q] <= data_i;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (pop_ok) rptr_q <= rptr_q + 1'b1;
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  push_full_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && !flush_i && full));

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch stage: one outstanding imem request at a time, fetched
// words buffered with their PC+4, flushed and restarted on a taken branch.
module fetch_prefetch_queue
  import fetch_prefetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   redirect_i,
  input  logic [31:0]            redirect_pc_i,
  output logic                   imem_req_o,
  output logic [31:0]            imem_addr_o,
  input  logic                   imem_ack_i,
  input  logic [31:0]            imem_rdata_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [31:0]            out_instr_o,
  output logic [31:0]            out_pc4_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  state_e        state_q;
  logic [31:0]   fetch_pc_q;
  logic [31:0]   req_addr_q;
  logic          imem_req_q;
  logic [CW-1:0] count;
  logic [CW-1:0] count_d;
  logic [31:0]   next_addr;
  logic [31:0]   redirect_tgt;
  logic          push;
  logic          pop;
  entry_t        push_entry;
  entry_t        head;
  logic          unused_pc_lsbs;

  assign redirect_tgt   = {redirect_pc_i[31:2], 2'b00};
  assign unused_pc_lsbs = ^redirect_pc_i[1:0];
  assign next_addr      = req_addr_q + PC_STEP;
  assign pop            = out_valid_o && out_ready_i && !redirect_i;
  assign push           = (state_q == FETCH) && imem_ack_i && !redirect_i;
  assign count_d        = count + CW'(push) - CW'(pop);
  assign push_entry     = '{instr: imem_rdata_i, pc4: next_addr};

  prefetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (redirect_i),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .data_o  (head),
    .count_o (count)
  );

  // A redirect with the request still in flight must wait out the stale ack
  // in DRAIN; otherwise the FSM returns to IDLE and refetches next cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      imem_req_q <= 1'b0;
    end else if (redirect_i) begin
      fetch_pc_q <= redirect_tgt;
      if ((state_q == FETCH || state_q == DRAIN) && !imem_ack_i) begin
        state_q <= DRAIN;
      end else begin
        state_q    <= IDLE;
        imem_req_q <= 1'b0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (count < FULL_CNT) begin
            req_addr_q <= fetch_pc_q;
            imem_req_q <= 1'b1;
            state_q    <= FETCH;
          end
        end
        FETCH: begin
          if (imem_ack_i) begin
            fetch_pc_q <= next_addr;
            if (count_d < FULL_CNT) begin
              req_addr_q <= next_addr;
            end else begin
              imem_req_q <= 1'b0;
              state_q    <= IDLE;
            end
          end
        end
        DRAIN: begin
          if (imem_ack_i) begin
            imem_req_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: begin
          imem_req_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign imem_req_o  = imem_req_q;
  assign imem_addr_o = req_addr_q;
  assign out_valid_o = (count != '0);
  assign out_instr_o = head.instr;
  assign out_pc4_o   = head.pc4;
  assign count_o     = count;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Randomized bench for fetch_prefetch_queue: a latency-configurable memory
// responder plus an in-order address scoreboard of what IF/ID should see.
module tb_fetch_prefetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc4;
  logic [2:0]  count;

  logic        imem_req2;
  logic [31:0] imem_addr2;
  logic        imem_ack2;
  logic [31:0] imem_rdata2;
  logic        out_valid2;
  logic [31:0] out_instr2;
  logic [31:0] out_pc42;
  logic [2:0]  count2;
  logic        redirect2 = 1'b0;
  logic        out_ready2 = 1'b1;

  fetch_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk_i(clk), .rst_ni(rst_n), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_ack_i(imem_ack),
    .imem_rdata_i(imem_rdata), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_instr_o(out_instr), .out_pc4_o(out_pc4), .count_o(count)
  );

  fetch_prefetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dutWrap (
    .clk_i(clk), .rst_ni(rst_n), .redirect_i(redirect2), .redirect_pc_i(32'h0),
    .imem_req_o(imem_req2), .imem_addr_o(imem_addr2), .imem_ack_i(imem_ack2),
    .imem_rdata_i(imem_rdata2), .out_valid_o(out_valid2), .out_ready_i(out_ready2),
    .out_instr_o(out_instr2), .out_pc4_o(out_pc42), .count_o(count2)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          popCount = 0;
  int          lastPopCyc = 0;
  int          waitCnt = 0;
  int          delayTarget = 0;
  logic [31:0] expAddr;
  logic [31:0] expAddr2;
  logic        prevReq = 1'b0;
  logic        prevAck = 1'b0;
  logic        prevRedirect = 1'b0;
  logic [31:0] prevAddr = 32'h0;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  // Called just after a falling edge: check, drive one cycle of inputs, update
  // the reference, then advance to the next falling edge.
  task automatic applyStimulus(input bit rdy, input bit rd, input logic [31:0] rpc,
                               input int minD, input int maxD);
    checkOutput("valid_vs_count", 32'(out_valid), 32'(count != 3'd0));
    checkOutput("count_bound", 32'(count <= 3'd4), 32'd1);
    if (prevReq && !prevAck) begin
      checkOutput("req_held", 32'(imem_req), 32'd1);
      checkOutput("addr_held", imem_addr, prevAddr);
    end
    if (prevRedirect) begin
      checkOutput("flush_count", 32'(count), 32'd0);
      checkOutput("flush_valid", 32'(out_valid), 32'd0);
    end
    if (imem_req) checkOutput("addr_align", 32'(imem_addr[1:0]), 32'd0);

    if (imem_req && waitCnt >= delayTarget) begin
      imem_ack    = 1'b1;
      imem_rdata  = memWord(imem_addr);
      waitCnt     = 0;
      delayTarget = $urandom_range(maxD, minD);
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      if (imem_req) waitCnt++;
      else begin
        waitCnt     = 0;
        delayTarget = $urandom_range(maxD, minD);
      end
    end
    out_ready   = rdy;
    redirect    = rd;
    redirect_pc = rpc;
    imem_ack2   = imem_req2;
    imem_rdata2 = memWord(imem_addr2);

    if (rd) begin
      expAddr = {rpc[31:2], 2'b00};
    end else if (out_valid && rdy) begin
      checkOutput("pop_pc4", out_pc4, expAddr + 32'd4);
      checkOutput("pop_instr", out_instr, memWord(expAddr));
      expAddr    = expAddr + 32'd4;
      popCount++;
      lastPopCyc = cyc;
    end
    if (out_valid2) begin
      checkOutput("wrap_pc4", out_pc42, expAddr2 + 32'd4);
      checkOutput("wrap_instr", out_instr2, memWord(expAddr2));
      expAddr2 = expAddr2 + 32'd4;
    end

    prevReq      = imem_req;
    prevAddr     = imem_addr;
    prevAck      = imem_ack;
    prevRedirect = rd;
    @(negedge clk);
    cyc++;
  endtask

  task automatic doReset();
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
    imem_ack = 1'b0; imem_rdata = 32'h0; imem_ack2 = 1'b0; imem_rdata2 = 32'h0;
    repeat (2) @(negedge clk);
    checkOutput("rst_req", 32'(imem_req), 32'd0);
    checkOutput("rst_addr", imem_addr, 32'h0);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_instr", out_instr, 32'h0);
    checkOutput("rst_pc4", out_pc4, 32'h0);
    checkOutput("rst_wrap_addr", imem_addr2, 32'hFFFF_FFF8);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("first_req", 32'(imem_req), 32'd1);
    checkOutput("first_addr", imem_addr, 32'h0);
    checkOutput("wrap_first_addr", imem_addr2, 32'hFFFF_FFF8);
    expAddr = 32'h0; expAddr2 = 32'hFFFF_FFF8;
    prevReq = 1'b0; prevAck = 1'b0; prevRedirect = 1'b0;
    waitCnt = 0; delayTarget = 0;
  endtask

  task automatic waitOutstanding();
    bit found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 3, 3);
      found = imem_req && (waitCnt == 1);
    end
    checkOutput("outstanding_seen", 32'(found), 32'd1);
  endtask

  // After a redirect: the stale ack must come back, then the next request
  // must target the (last) redirect address.
  task automatic waitNewRequest(input string tag, input logic [31:0] target);
    bit seenAck = 1'b0;
    bit found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (seenAck && imem_req) begin
        found = 1'b1;
        checkOutput(tag, imem_addr, target);
      end else begin
        applyStimulus(1'b1, 1'b0, 32'h0, 3, 3);
        if (imem_ack) seenAck = 1'b1;
      end
    end
    checkOutput("new_request_seen", 32'(found), 32'd1);
  endtask

  initial begin
    int          p0;
    int          pops[$];
    bit          found;
    bit          rd;
    logic [31:0] tgt;

    doReset();

    // Single-cycle memory, always ready: one instruction per cycle.
    repeat (3) applyStimulus(1'b1, 1'b0, 32'h0, 0, 0);
    p0 = popCount;
    repeat (20) applyStimulus(1'b1, 1'b0, 32'h0, 0, 0);
    checkOutput("throughput_pops", popCount - p0, 32'd20);

    // Stall: queue fills to DEPTH and fetching stops.
    repeat (10) applyStimulus(1'b0, 1'b0, 32'h0, 0, 0);
    checkOutput("stall_count", 32'(count), 32'd4);
    checkOutput("stall_req", 32'(imem_req), 32'd0);
    found = 1'b0;
    for (int i = 0; i < 4 && !found; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 0, 0);
      found = imem_req;
    end
    checkOutput("resume_req", 32'(found), 32'd1);

    // Three-cycle ack delay: one instruction every four cycles.
    repeat (30) applyStimulus(1'b1, 1'b0, 32'h0, 3, 3);
    for (int i = 0; i < 60 && pops.size() < 4; i++) begin
      p0 = popCount;
      applyStimulus(1'b1, 1'b0, 32'h0, 3, 3);
      if (popCount != p0) pops.push_back(lastPopCyc);
    end
    checkOutput("period_pops", pops.size(), 32'd4);
    if (pops.size() == 4)
      for (int i = 1; i < 4; i++) checkOutput("period_gap", pops[i] - pops[i-1], 32'd4);

    // Redirect with a request in flight; stale data must be dropped.
    waitOutstanding();
    applyStimulus(1'b1, 1'b1, 32'h0000_0041, 3, 3);
    checkOutput("drain_req", 32'(imem_req), 32'd1);
    waitNewRequest("redirect_addr", 32'h0000_0040);
    for (int i = 0; i < 20 && !out_valid; i++) applyStimulus(1'b1, 1'b0, 32'h0, 3, 3);
    checkOutput("first_out_pc4", out_pc4, 32'h0000_0044);

    // Redirect on the same edge as an ack and a pop with the queue near full.
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (count == 3'd3 && imem_req && waitCnt >= delayTarget) found = 1'b1;
      else applyStimulus(1'b0, 1'b0, 32'h0, 0, 0);
    end
    checkOutput("near_full_seen", 32'(found), 32'd1);
    applyStimulus(1'b1, 1'b1, 32'h0000_0100, 0, 0);
    checkOutput("coincident_count", 32'(count), 32'd0);
    checkOutput("coincident_req", 32'(imem_req), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0, 3, 3);
    checkOutput("restart_req", 32'(imem_req), 32'd1);
    checkOutput("restart_addr", imem_addr, 32'h0000_0100);

    // Second redirect while draining retargets the restart.
    waitOutstanding();
    applyStimulus(1'b1, 1'b1, 32'h0000_0200, 3, 3);
    applyStimulus(1'b1, 1'b1, 32'h0000_0302, 3, 3);
    waitNewRequest("drain_retarget_addr", 32'h0000_0300);

    // Random traffic: latency, back-pressure and redirects all mixed.
    for (int i = 0; i < 3000; i++) begin
      rd  = ($urandom_range(0, 29) == 0);
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                        : ($urandom & 32'h0000_0FFF);
      applyStimulus($urandom_range(0, 3) != 0, rd, tgt, 0, 3);
    end

    // Reset mid-request drops the request without waiting for a clock.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 3, 3);
      found = imem_req;
    end
    checkOutput("pre_reset_req", 32'(found), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("async_drop_req", 32'(imem_req), 32'd0);
    checkOutput("async_count", 32'(count), 32'd0);
    doReset();
    repeat (12) applyStimulus(1'b1, 1'b0, 32'h0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
